// File: rtl/decode_stage_hs_pkg.sv
// Shared definitions for the handshaked decode stage: instruction field
// positions, immediate-extension modes and default widths.
package decode_stage_hs_pkg;

   localparam int DEF_DATA_WIDTH     = 32;
   localparam int DEF_PC_WIDTH       = 32;
   localparam int DEF_INSTR_WIDTH    = 32;
   localparam int DEF_REG_ADDR_WIDTH = 5;
   localparam int DEF_NUM_REGS       = 16;
   localparam int DEF_CTRL_WIDTH     = 20;

   localparam int OPCODE_WIDTH = 6;
   localparam int FUNCT_WIDTH  = 6;
   localparam int IMM_WIDTH    = 16;
   localparam int JTGT_WIDTH   = 26;

   localparam int OPCODE_MSB = 31;
   localparam int OPCODE_LSB = 26;
   localparam int RS_MSB     = 25;
   localparam int RS_LSB     = 21;
   localparam int RT_MSB     = 20;
   localparam int RT_LSB     = 16;
   localparam int RD_MSB     = 15;
   localparam int RD_LSB     = 11;
   localparam int IMM_MSB    = 15;
   localparam int IMM_LSB    = 0;
   localparam int FUNCT_MSB  = 5;
   localparam int FUNCT_LSB  = 0;
   localparam int JTGT_MSB   = 25;
   localparam int JTGT_LSB   = 0;

   // Mode 3 is an alias of sign-extension so every encoding is defined.
   typedef enum logic [1:0] {
      IMM_SIGN     = 2'd0,
      IMM_ZERO     = 2'd1,
      IMM_UPPER    = 2'd2,
      IMM_SIGN_ALT = 2'd3
   } immMode_e;

endpackage

// File: rtl/decode_stage_hs_imm_extender.sv
// Widens the 16-bit immediate field to the operand width according to the
// extension mode chosen by the control unit.
module decode_stage_hs_imm_extender
   import decode_stage_hs_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic [IMM_WIDTH-1:0]  imm_i,
   input  logic [1:0]            mode_i,
   output logic [DATA_WIDTH-1:0] imm_o
);

   // Pick sign, zero or upper-half placement of the immediate.
   always_comb begin
      imm_o = DATA_WIDTH'($signed(imm_i));
      case (immMode_e'(mode_i))
         IMM_SIGN:     imm_o = DATA_WIDTH'($signed(imm_i));
         IMM_ZERO:     imm_o = DATA_WIDTH'(imm_i);
         IMM_UPPER:    imm_o = DATA_WIDTH'({imm_i, 16'h0000});
         IMM_SIGN_ALT: imm_o = DATA_WIDTH'($signed(imm_i));
         default:      imm_o = DATA_WIDTH'($signed(imm_i));
      endcase
   end

endmodule

// File: rtl/decode_stage_hs.sv
// Decode stage with valid/ready on both sides. Holds one fetched
// instruction, drives register-file and control-unit lookups, and registers
// the decoded bundle into the EX-facing pipeline register. Supports hazard
// bubbles (instruction held and retried), flush, and jump redirection.
module decode_stage_hs
   import decode_stage_hs_pkg::*;
#(
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int PC_WIDTH       = DEF_PC_WIDTH,
   parameter int INSTR_WIDTH    = DEF_INSTR_WIDTH,
   parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
   parameter int NUM_REGS       = DEF_NUM_REGS,
   parameter int CTRL_WIDTH     = DEF_CTRL_WIDTH
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [INSTR_WIDTH-1:0]    in_instr,
   input  logic [PC_WIDTH-1:0]       in_pc,
   input  logic                      flush,
   input  logic                      stall_hazard,
   output logic [OPCODE_WIDTH-1:0]   opcode,
   output logic [FUNCT_WIDTH-1:0]    funct,
   input  logic [CTRL_WIDTH-1:0]     ctrl_in,
   input  logic                      ctrl_is_jump,
   input  logic                      ctrl_sel_j_jr,
   input  logic [1:0]                imm_mode,
   output logic [REG_ADDR_WIDTH-1:0] rf_rs,
   output logic [REG_ADDR_WIDTH-1:0] rf_rt,
   input  logic [DATA_WIDTH-1:0]     rf_data_rs,
   input  logic [DATA_WIDTH-1:0]     rf_data_rt,
   output logic                      is_jump,
   output logic [PC_WIDTH-1:0]       jump_addr,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [CTRL_WIDTH-1:0]     out_ctrl,
   output logic [REG_ADDR_WIDTH-1:0] out_rs,
   output logic [REG_ADDR_WIDTH-1:0] out_rt,
   output logic [REG_ADDR_WIDTH-1:0] out_rd,
   output logic [DATA_WIDTH-1:0]     out_imm,
   output logic [DATA_WIDTH-1:0]     out_data_rs,
   output logic [DATA_WIDTH-1:0]     out_data_rt,
   output logic [PC_WIDTH-1:0]       out_next_pc
);

   localparam logic [REG_ADDR_WIDTH-1:0] MAX_ADDR = REG_ADDR_WIDTH'(NUM_REGS - 1);

   // Decode register
   logic                   decValid_q, decValid_d;
   logic [INSTR_WIDTH-1:0] decInstr_q, decInstr_d;
   logic [PC_WIDTH-1:0]    decPc_q,    decPc_d;

   // EX-facing output register
   logic                      outValid_q,  outValid_d;
   logic [CTRL_WIDTH-1:0]     outCtrl_q,   outCtrl_d;
   logic [REG_ADDR_WIDTH-1:0] outRs_q,     outRs_d;
   logic [REG_ADDR_WIDTH-1:0] outRt_q,     outRt_d;
   logic [REG_ADDR_WIDTH-1:0] outRd_q,     outRd_d;
   logic [DATA_WIDTH-1:0]     outImm_q,    outImm_d;
   logic [DATA_WIDTH-1:0]     outDataRs_q, outDataRs_d;
   logic [DATA_WIDTH-1:0]     outDataRt_q, outDataRt_d;
   logic [PC_WIDTH-1:0]       outNextPc_q, outNextPc_d;

   logic                      adv;
   logic                      accept;
   logic                      transfer;
   logic [REG_ADDR_WIDTH-1:0] rsRaw;
   logic [REG_ADDR_WIDTH-1:0] rtRaw;
   logic [REG_ADDR_WIDTH-1:0] rdRaw;
   logic [DATA_WIDTH-1:0]     immExt;
   logic                      unusedInstr;

   // The output register may take new contents when empty or being drained.
   assign adv      = !outValid_q || out_ready;
   assign in_ready = !decValid_q || (adv && !stall_hazard);
   assign accept   = in_valid && in_ready;
   assign transfer = decValid_q && adv && !stall_hazard && !flush;

   assign rsRaw = REG_ADDR_WIDTH'(decInstr_q[RS_MSB:RS_LSB]);
   assign rtRaw = REG_ADDR_WIDTH'(decInstr_q[RT_MSB:RT_LSB]);
   assign rdRaw = REG_ADDR_WIDTH'(decInstr_q[RD_MSB:RD_LSB]);

   // Shamt bits and any bits above the MIPS-style 32-bit word are not decoded.
   assign unusedInstr = ^decInstr_q;

   assign opcode = decInstr_q[OPCODE_MSB:OPCODE_LSB];
   assign funct  = decInstr_q[FUNCT_MSB:FUNCT_LSB];

   // Addresses beyond the implemented file are clamped to the top register.
   assign rf_rs = (32'(rsRaw) >= 32'(NUM_REGS)) ? MAX_ADDR : rsRaw;
   assign rf_rt = (32'(rtRaw) >= 32'(NUM_REGS)) ? MAX_ADDR : rtRaw;

   assign is_jump   = decValid_q && ctrl_is_jump && !stall_hazard && !flush;
   assign jump_addr = ctrl_sel_j_jr ? PC_WIDTH'(decInstr_q[JTGT_MSB:JTGT_LSB])
                                    : PC_WIDTH'(rf_data_rs);

   decode_stage_hs_imm_extender #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_immExt (
      .imm_i  (decInstr_q[IMM_MSB:IMM_LSB]),
      .mode_i (imm_mode),
      .imm_o  (immExt)
   );

   // Decode register next state: a new accept wins even over flush, so a
   // branch target presented with the flush is kept.
   always_comb begin
      decValid_d = decValid_q;
      decInstr_d = decInstr_q;
      decPc_d    = decPc_q;
      if (accept) begin
         decValid_d = 1'b1;
         decInstr_d = in_instr;
         decPc_d    = in_pc;
      end else if (flush || transfer) begin
         decValid_d = 1'b0;
      end
   end

   // Output register next state: flush kills, transfer loads, bubble/idle
   // invalidates, and backpressure holds everything.
   always_comb begin
      outValid_d  = outValid_q;
      outCtrl_d   = outCtrl_q;
      outRs_d     = outRs_q;
      outRt_d     = outRt_q;
      outRd_d     = outRd_q;
      outImm_d    = outImm_q;
      outDataRs_d = outDataRs_q;
      outDataRt_d = outDataRt_q;
      outNextPc_d = outNextPc_q;
      if (flush) begin
         outValid_d = 1'b0;
         outCtrl_d  = '0;
      end else if (transfer) begin
         outValid_d  = 1'b1;
         outCtrl_d   = ctrl_in;
         outRs_d     = rsRaw;
         outRt_d     = rtRaw;
         outRd_d     = rdRaw;
         outImm_d    = immExt;
         outDataRs_d = rf_data_rs;
         outDataRt_d = rf_data_rt;
         outNextPc_d = decPc_q + PC_WIDTH'(1);
      end else if (adv) begin
         outValid_d = 1'b0;
         outCtrl_d  = '0;
      end
   end

   // Both pipeline registers clear immediately on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         decValid_q  <= 1'b0;
         decInstr_q  <= '0;
         decPc_q     <= '0;
         outValid_q  <= 1'b0;
         outCtrl_q   <= '0;
         outRs_q     <= '0;
         outRt_q     <= '0;
         outRd_q     <= '0;
         outImm_q    <= '0;
         outDataRs_q <= '0;
         outDataRt_q <= '0;
         outNextPc_q <= '0;
      end else begin
         decValid_q  <= decValid_d;
         decInstr_q  <= decInstr_d;
         decPc_q     <= decPc_d;
         outValid_q  <= outValid_d;
         outCtrl_q   <= outCtrl_d;
         outRs_q     <= outRs_d;
         outRt_q     <= outRt_d;
         outRd_q     <= outRd_d;
         outImm_q    <= outImm_d;
         outDataRs_q <= outDataRs_d;
         outDataRt_q <= outDataRt_d;
         outNextPc_q <= outNextPc_d;
      end
   end

   assign out_valid   = outValid_q;
   assign out_ctrl    = outCtrl_q;
   assign out_rs      = outRs_q;
   assign out_rt      = outRt_q;
   assign out_rd      = outRd_q;
   assign out_imm     = outImm_q;
   assign out_data_rs = outDataRs_q;
   assign out_data_rt = outDataRt_q;
   assign out_next_pc = outNextPc_q;

endmodule

// File: tb/tb_decode_stage_hs.sv
// Directed bench for decode_stage_hs: streaming, backpressure, hazard
// bubbles, flush with concurrent accept, immediate modes, address clamping,
// jumps and asynchronous reset.
module tb_decode_stage_hs;

   localparam int DW = 32;
   localparam int PW = 32;
   localparam int IW = 32;
   localparam int AW = 5;
   localparam int CW = 20;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [IW-1:0] in_instr;
   logic [PW-1:0] in_pc;
   logic          flush;
   logic          stall_hazard;
   logic [5:0]    opcode;
   logic [5:0]    funct;
   logic [CW-1:0] ctrl_in;
   logic          ctrl_is_jump;
   logic          ctrl_sel_j_jr;
   logic [1:0]    imm_mode;
   logic [AW-1:0] rf_rs;
   logic [AW-1:0] rf_rt;
   logic [DW-1:0] rf_data_rs;
   logic [DW-1:0] rf_data_rt;
   logic          is_jump;
   logic [PW-1:0] jump_addr;
   logic          out_valid;
   logic          out_ready;
   logic [CW-1:0] out_ctrl;
   logic [AW-1:0] out_rs;
   logic [AW-1:0] out_rt;
   logic [AW-1:0] out_rd;
   logic [DW-1:0] out_imm;
   logic [DW-1:0] out_data_rs;
   logic [DW-1:0] out_data_rt;
   logic [PW-1:0] out_next_pc;

   logic [DW-1:0] rfMem [16];

   int passCount = 0;
   int checkCount = 0;

   decode_stage_hs dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_instr     (in_instr),
      .in_pc        (in_pc),
      .flush        (flush),
      .stall_hazard (stall_hazard),
      .opcode       (opcode),
      .funct        (funct),
      .ctrl_in      (ctrl_in),
      .ctrl_is_jump (ctrl_is_jump),
      .ctrl_sel_j_jr(ctrl_sel_j_jr),
      .imm_mode     (imm_mode),
      .rf_rs        (rf_rs),
      .rf_rt        (rf_rt),
      .rf_data_rs   (rf_data_rs),
      .rf_data_rt   (rf_data_rt),
      .is_jump      (is_jump),
      .jump_addr    (jump_addr),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_ctrl     (out_ctrl),
      .out_rs       (out_rs),
      .out_rt       (out_rt),
      .out_rd       (out_rd),
      .out_imm      (out_imm),
      .out_data_rs  (out_data_rs),
      .out_data_rt  (out_data_rt),
      .out_next_pc  (out_next_pc)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   // Stand-in control unit and register file.
   assign ctrl_in    = {opcode, funct, 8'hA5};
   assign rf_data_rs = rfMem[rf_rs[3:0]];
   assign rf_data_rt = rfMem[rf_rt[3:0]];

   function automatic logic [31:0] mkI(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [CW-1:0] ctrlOf(input logic [31:0] instr);
      return {instr[31:26], instr[5:0], 8'hA5};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [31:0] pc);
      in_valid = v;
      in_instr = instr;
      in_pc    = pc;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
   endtask

   localparam logic [31:0] INSTR_A  = 32'h2022_0005;
   localparam logic [31:0] INSTR_B  = 32'h2064_0010;
   localparam logic [31:0] INSTR_C  = 32'h34A6_8001;
   localparam logic [31:0] INSTR_D  = 32'h8CE8_0004;
   localparam logic [31:0] INSTR_E  = 32'h2000_0001;
   localparam logic [31:0] INSTR_T  = 32'h112A_0002;
   localparam logic [31:0] INSTR_F  = 32'h3291_8001;
   localparam logic [31:0] INSTR_J  = 32'h0800_0123;
   localparam logic [31:0] INSTR_JR = 32'h0060_0008;

   initial begin
      for (int i = 0; i < 16; i++) rfMem[i] = 32'hA000_0000 | 32'(i);
      rst = 1'b1;
      in_valid = 1'b0; in_instr = '0; in_pc = '0;
      flush = 1'b0; stall_hazard = 1'b0;
      ctrl_is_jump = 1'b0; ctrl_sel_j_jr = 1'b0;
      imm_mode = 2'd0; out_ready = 1'b1;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
      checkOutput("rst_out_ctrl", 64'(out_ctrl), 64'd0);
      checkOutput("rst_next_pc", 64'(out_next_pc), 64'd0);
      checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
      checkOutput("rst_is_jump", 64'(is_jump), 64'd0);
      rst = 1'b0;

      // Streaming A, B, C
      applyStimulus(1'b1, INSTR_A, 32'd0);
      checkOutput("s_in_ready", 64'(in_ready), 64'd1);
      tick();
      applyStimulus(1'b1, INSTR_B, 32'd1);
      checkOutput("s_a_not_yet", 64'(out_valid), 64'd0);
      checkOutput("s_opcode_a", 64'(opcode), 64'h08);
      checkOutput("s_rf_rs_a", 64'(rf_rs), 64'd1);
      tick();
      applyStimulus(1'b1, INSTR_C, 32'd2);
      checkOutput("s_a_valid", 64'(out_valid), 64'd1);
      checkOutput("s_a_pc", 64'(out_next_pc), 64'd1);
      checkOutput("s_a_ctrl", 64'(out_ctrl), 64'(ctrlOf(INSTR_A)));
      checkOutput("s_a_data_rs", 64'(out_data_rs), 64'hA000_0001);
      checkOutput("s_a_data_rt", 64'(out_data_rt), 64'hA000_0002);
      checkOutput("s_a_imm", 64'(out_imm), 64'h5);
      tick();
      checkOutput("s_b_valid", 64'(out_valid), 64'd1);
      checkOutput("s_b_pc", 64'(out_next_pc), 64'd2);

      // Backpressure with B in out and C in decode
      out_ready = 1'b0;
      applyStimulus(1'b0, 32'h0, 32'h0);
      checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
      tick();
      checkOutput("bp_hold_pc1", 64'(out_next_pc), 64'd2);
      checkOutput("bp_hold_valid", 64'(out_valid), 64'd1);
      tick();
      tick();
      checkOutput("bp_hold_pc3", 64'(out_next_pc), 64'd2);
      checkOutput("bp_hold_ctrl", 64'(out_ctrl), 64'(ctrlOf(INSTR_B)));
      checkOutput("bp_in_ready_late", 64'(in_ready), 64'd0);
      out_ready = 1'b1;
      #1;
      checkOutput("bp_release_ready", 64'(in_ready), 64'd1);
      tick();
      checkOutput("bp_c_pc", 64'(out_next_pc), 64'd3);
      checkOutput("bp_c_imm_sign", 64'(out_imm), 64'hFFFF_8001);

      // Hazard: D held for two bubbles, then issued once
      applyStimulus(1'b1, INSTR_D, 32'd10);
      tick();
      checkOutput("hz_idle_valid", 64'(out_valid), 64'd0);
      stall_hazard = 1'b1;
      applyStimulus(1'b0, 32'h0, 32'h0);
      checkOutput("hz_in_ready", 64'(in_ready), 64'd0);
      tick();
      checkOutput("hz_bubble1_valid", 64'(out_valid), 64'd0);
      checkOutput("hz_bubble1_ctrl", 64'(out_ctrl), 64'd0);
      tick();
      checkOutput("hz_bubble2_valid", 64'(out_valid), 64'd0);
      checkOutput("hz_bubble2_ctrl", 64'(out_ctrl), 64'd0);
      rfMem[7] = 32'h0000_7777;
      stall_hazard = 1'b0;
      tick();
      checkOutput("hz_d_valid", 64'(out_valid), 64'd1);
      checkOutput("hz_d_pc", 64'(out_next_pc), 64'd11);
      checkOutput("hz_d_data_rs", 64'(out_data_rs), 64'h7777);
      checkOutput("hz_d_data_rt", 64'(out_data_rt), 64'hA000_0008);
      tick();
      checkOutput("hz_d_once", 64'(out_valid), 64'd0);

      // Flush while E sits in decode and target T is presented
      applyStimulus(1'b1, INSTR_E, 32'd20);
      tick();
      flush = 1'b1;
      applyStimulus(1'b1, INSTR_T, 32'd40);
      checkOutput("fl_in_ready", 64'(in_ready), 64'd1);
      tick();
      flush = 1'b0;
      applyStimulus(1'b0, 32'h0, 32'h0);
      checkOutput("fl_valid_killed", 64'(out_valid), 64'd0);
      checkOutput("fl_ctrl_killed", 64'(out_ctrl), 64'd0);
      tick();
      checkOutput("fl_t_valid", 64'(out_valid), 64'd1);
      checkOutput("fl_t_pc", 64'(out_next_pc), 64'd41);
      checkOutput("fl_t_data_rs", 64'(out_data_rs), 64'hA000_0009);
      tick();
      checkOutput("fl_no_e", 64'(out_valid), 64'd0);

      // Immediate modes and register clamping
      applyStimulus(1'b1, INSTR_F, 32'd50);
      tick();
      checkOutput("cl_rf_rs", 64'(rf_rs), 64'd15);
      checkOutput("cl_rf_rt", 64'(rf_rt), 64'd15);
      imm_mode = 2'd0;
      applyStimulus(1'b1, INSTR_F, 32'd51);
      tick();
      checkOutput("im_sign", 64'(out_imm), 64'hFFFF_8001);
      checkOutput("cl_out_rs", 64'(out_rs), 64'd20);
      checkOutput("cl_out_rt", 64'(out_rt), 64'd17);
      checkOutput("cl_out_rd", 64'(out_rd), 64'd16);
      checkOutput("cl_data_rs", 64'(out_data_rs), 64'hA000_000F);
      imm_mode = 2'd1;
      applyStimulus(1'b1, INSTR_F, 32'd52);
      tick();
      checkOutput("im_zero", 64'(out_imm), 64'h0000_8001);
      imm_mode = 2'd2;
      applyStimulus(1'b0, 32'h0, 32'h0);
      tick();
      checkOutput("im_upper", 64'(out_imm), 64'h8001_0000);
      checkOutput("im_upper_pc", 64'(out_next_pc), 64'd53);
      imm_mode = 2'd0;

      // Absolute jump
      applyStimulus(1'b1, INSTR_J, 32'd60);
      tick();
      ctrl_is_jump = 1'b1;
      ctrl_sel_j_jr = 1'b1;
      applyStimulus(1'b0, 32'h0, 32'h0);
      checkOutput("j_is_jump", 64'(is_jump), 64'd1);
      checkOutput("j_addr", 64'(jump_addr), 64'h123);
      stall_hazard = 1'b1;
      #1;
      checkOutput("j_stalled", 64'(is_jump), 64'd0);
      stall_hazard = 1'b0;
      tick();
      checkOutput("j_empty", 64'(is_jump), 64'd0);
      checkOutput("j_out_pc", 64'(out_next_pc), 64'd61);

      // Register-indirect jump
      rfMem[3] = 32'h0000_0040;
      applyStimulus(1'b1, INSTR_JR, 32'd70);
      tick();
      ctrl_sel_j_jr = 1'b0;
      applyStimulus(1'b0, 32'h0, 32'h0);
      checkOutput("jr_is_jump", 64'(is_jump), 64'd1);
      checkOutput("jr_addr", 64'(jump_addr), 64'h40);
      flush = 1'b1;
      #1;
      checkOutput("jr_flushed", 64'(is_jump), 64'd0);
      flush = 1'b0;
      ctrl_is_jump = 1'b0;
      tick();
      checkOutput("jr_out_valid", 64'(out_valid), 64'd1);

      // Asynchronous reset between clock edges
      #2;
      rst = 1'b1;
      #1;
      checkOutput("ar_out_valid", 64'(out_valid), 64'd0);
      checkOutput("ar_next_pc", 64'(out_next_pc), 64'd0);
      checkOutput("ar_in_ready", 64'(in_ready), 64'd1);
      rst = 1'b0;

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/decode_stage_hs.md
Name: decode_stage_hs

Overview:
- Parametrised successor to the fixed-width decode stage. It holds one fetched instruction, drives register-file read addresses and control-unit decode fields, then registers operands, immediate, control bundle and pc+1 into an EX-facing pipeline register.
- Adds valid/ready handshakes on both sides, hazard-bubble insertion with instruction hold, flush, a selectable immediate-extension mode and register-address clamping to NUM_REGS.
- Sits between the fetch stage and the execute stage.

Parameters:
- DATA_WIDTH, 32, GPR/operand/immediate width.
- PC_WIDTH, 32, program-counter width.
- INSTR_WIDTH, 32, instruction width (fields at MIPS-style bit positions; must be ≥32).
- REG_ADDR_WIDTH, 5, register address width.
- NUM_REGS, 16, implemented registers; addresses ≥ NUM_REGS are clamped to NUM_REGS-1.
- CTRL_WIDTH, 20, width of the opaque control bundle from control_unit.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  fetch presents instruction/pc
- in_ready  out  1  stage accepts this cycle
- in_instr  in  INSTR_WIDTH  fetched instruction
- in_pc  in  PC_WIDTH  its pc
- flush  in  1  branch taken in MEM; kill in-flight contents
- stall_hazard  in  1  hazard unit requests a bubble
- opcode  out  6  dec_instr[31:26] to control_unit
- funct  out  6  dec_instr[5:0] to control_unit
- ctrl_in  in  CTRL_WIDTH  control bundle from control_unit
- ctrl_is_jump  in  1  control_unit: unconditional jump
- ctrl_sel_j_jr  in  1  1 = absolute j target, 0 = jr (data_rs)
- imm_mode  in  2  0 = sign-extend, 1 = zero-extend, 2 = imm<<16, 3 = sign-extend
- rf_rs, rf_rt  out  REG_ADDR_WIDTH each  clamped read addresses
- rf_data_rs, rf_data_rt  in  DATA_WIDTH each  combinational read data
- is_jump  out  1  redirect fetch
- jump_addr  out  PC_WIDTH  jump target
- out_valid  out  1  EX register holds a real instruction
- out_ready  in  1  EX accepts
- out_ctrl  out  CTRL_WIDTH  registered control bundle
- out_rs, out_rt, out_rd  out  REG_ADDR_WIDTH each  raw (unclamped) fields
- out_imm  out  DATA_WIDTH  extended immediate
- out_data_rs, out_data_rt  out  DATA_WIDTH each  operand data
- out_next_pc  out  PC_WIDTH  pc+1

Behaviour:
- Two registers: decode reg (dec_valid, dec_instr, dec_pc) and output reg (all out_*).
- Reset: every out_* is zero, out_valid = 0, dec_valid = 0, dec_instr = 0, dec_pc = 0.
- adv = !out_valid || out_ready.
- in_ready = !dec_valid || (adv && !stall_hazard). This is combinational; flush does not gate it.
- Accept when in_valid && in_ready: decode reg loads at the edge.
- Latency: accepted at edge N, presented on out_* after edge N+1 when adv is high and there is no stall.
- Transfer dec→out at an edge when dec_valid && adv && !stall_hazard && !flush:
  - out_valid = 1; out_ctrl = ctrl_in; out_data_* = rf_data_*; out_next_pc = dec_pc+1 (mod 2^PC_WIDTH).
  - out_imm is extended per imm_mode.
  - dec_valid clears unless a new instruction is accepted in the same cycle.
- Bubble: when dec_valid && stall_hazard && adv, out_valid = 0 and out_ctrl = 0. The decode reg holds, and the same instruction retries next cycle.
- When !adv, the output reg holds all fields unchanged; the decode reg holds as well.
- Flush: at the edge, out_valid = 0, out_ctrl = 0 and the current dec_valid is dropped. An instruction accepted in the same cycle (the branch target) is loaded with dec_valid = 1.
- Idle (no dec_valid) with adv: out_valid = 0 and out_ctrl = 0.
- rf_rs = dec_instr[25:21], clamped to NUM_REGS-1 when ≥ NUM_REGS; rf_rt uses [20:16] with the same rule.
- Jump outputs:
  - is_jump = dec_valid && ctrl_is_jump && !stall_hazard && !flush.
  - jump_addr = zero-extended dec_instr[25:0] when ctrl_sel_j_jr = 1, else rf_data_rs truncated/extended to PC_WIDTH.
- Reset asserted mid-operation: both registers clear immediately, independent of clk.

Decomposition:
- Shared package/defs: field bit positions, opcode/funct widths, IMM_SIGN/IMM_ZERO/IMM_UPPER constants, defaults for DATA_WIDTH/PC_WIDTH/REG_ADDR_WIDTH.
- One natural sub-module: imm_extender (combinational, DATA_WIDTH, imm_mode).
- control_unit stays external and is reached through the opcode/funct and ctrl_* ports.

Test Plan:
1. Reset then streaming: in_valid = 1 with instrs A,B,C at pc 0,1,2 and out_ready = 1 → out_valid rises one edge after each accept; out_next_pc = 1,2,3; throughput 1/cycle.
2. Backpressure: out_ready = 0 for 3 cycles with A in out and B in dec → out fields stable, in_ready = 0; release → B emerges the next edge, no loss or duplication.
3. Hazard: stall_hazard = 1 for 2 cycles on B → two bubbles with out_valid = 0 and out_ctrl = 0, in_ready = 0; B is then issued once with the correct rf data.
4. Flush with concurrent accept: flush = 1 while dec holds B and target T is presented → B never appears, out_valid = 0 the next cycle, T appears the cycle after.
5. Immediate/clamp: imm 16'h8001 → modes 0,1,2 give 32'hFFFF8001, 32'h00008001, 32'h80010000. rs field 20 with NUM_REGS = 16 → rf_rs = 15, out_rs = 20.
6. Jump: j with target 26'h0000123 → is_jump = 1, jump_addr = 32'h123. jr with rf_data_rs = 32'h40 → jump_addr = 32'h40. is_jump = 0 while stall_hazard = 1.
